// File: rtl/branch_target_id.sv
// branch_target_id
//   ID-stage branch-target unit. Extends the branch immediate (sign or zero),
//   scales it by SHIFT, adds it to the sequential PC and delivers the offset,
//   the target and a wrap flag through a PIPE-deep (1 or 2) valid-tagged
//   pipeline with stall/flush control.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid, is_branch   input qualifier and branch tag
//   sign_mode             1 = sign-extend imm, 0 = zero-extend
//   imm, pc_next          raw immediate, PC of the following instruction
//   stall, flush          hold all stages / invalidate all stages (flush wins)
//   out_valid, out_is_branch, out_offset, out_target, out_wrap
//                         registered results
module branch_target_id #(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int SHIFT  = 0,
  parameter int PIPE   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              is_branch,
  input  logic              sign_mode,
  input  logic [IMM_W-1:0]  imm,
  input  logic [ADDR_W-1:0] pc_next,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  output logic              out_is_branch,
  output logic [DATA_W-1:0] out_offset,
  output logic [ADDR_W-1:0] out_target,
  output logic              out_wrap
);

  // Two guard bits hold the exact sum: range is [-2^(ADDR_W-1), 2^(ADDR_W+1)-2].
  localparam int SUM_W = ADDR_W + 2;

  logic [DATA_W-1:0] ext;
  logic [DATA_W-1:0] offset_in;

  always_comb begin
    ext       = sign_mode ? DATA_W'($signed(imm)) : DATA_W'(imm);
    offset_in = ext << SHIFT;
  end

  // Operands seen by the adder: stage-1 registers for PIPE=2, raw inputs for PIPE=1.
  logic              f_valid;
  logic              f_branch;
  logic              f_sign;
  logic [ADDR_W-1:0] f_pc;
  logic [DATA_W-1:0] f_offset;

  if (PIPE == 2) begin : g_stage1
    logic              s1_valid_q,  s1_valid_d;
    logic              s1_branch_q, s1_branch_d;
    logic              s1_sign_q,   s1_sign_d;
    logic [ADDR_W-1:0] s1_pc_q,     s1_pc_d;
    logic [DATA_W-1:0] s1_offset_q, s1_offset_d;

    always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_branch_d = s1_branch_q;
      s1_sign_d   = s1_sign_q;
      s1_pc_d     = s1_pc_q;
      s1_offset_d = s1_offset_q;
      if (!stall) begin
        s1_branch_d = is_branch;
        s1_sign_d   = sign_mode;
        s1_pc_d     = pc_next;
        s1_offset_d = offset_in;
      end
      if (flush)       s1_valid_d = 1'b0;
      else if (!stall) s1_valid_d = in_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_valid_q  <= 1'b0;
        s1_branch_q <= 1'b0;
        s1_sign_q   <= 1'b0;
        s1_pc_q     <= '0;
        s1_offset_q <= '0;
      end else begin
        s1_valid_q  <= s1_valid_d;
        s1_branch_q <= s1_branch_d;
        s1_sign_q   <= s1_sign_d;
        s1_pc_q     <= s1_pc_d;
        s1_offset_q <= s1_offset_d;
      end
    end

    always_comb begin
      f_valid  = s1_valid_q;
      f_branch = s1_branch_q;
      f_sign   = s1_sign_q;
      f_pc     = s1_pc_q;
      f_offset = s1_offset_q;
    end
  end else begin : g_direct
    always_comb begin
      f_valid  = in_valid;
      f_branch = is_branch;
      f_sign   = sign_mode;
      f_pc     = pc_next;
      f_offset = offset_in;
    end
  end

  logic [ADDR_W-1:0] off_a;
  logic [SUM_W-1:0]  pc_e;
  logic [SUM_W-1:0]  off_e;
  logic [SUM_W-1:0]  sum;
  logic [ADDR_W-1:0] target_c;
  logic              wrap_c;

  always_comb begin
    off_a    = f_offset[ADDR_W-1:0];
    pc_e     = SUM_W'(f_pc);
    off_e    = f_sign ? SUM_W'($signed(off_a)) : SUM_W'(off_a);
    sum      = pc_e + off_e;
    target_c = sum[ADDR_W-1:0];
    // Negative sum sets the top guard bit; >= 2^ADDR_W sets bit ADDR_W.
    wrap_c   = |sum[SUM_W-1:ADDR_W];
  end

  logic              out_valid_q,  out_valid_d;
  logic              out_branch_q, out_branch_d;
  logic [DATA_W-1:0] out_offset_q, out_offset_d;
  logic [ADDR_W-1:0] out_target_q, out_target_d;
  logic              out_wrap_q,   out_wrap_d;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_branch_d = out_branch_q;
    out_offset_d = out_offset_q;
    out_target_d = out_target_q;
    out_wrap_d   = out_wrap_q;
    if (!stall) begin
      out_branch_d = f_branch;
      out_offset_d = f_offset;
      out_target_d = target_c;
      out_wrap_d   = wrap_c;
    end
    if (flush)       out_valid_d = 1'b0;
    else if (!stall) out_valid_d = f_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_branch_q <= 1'b0;
      out_offset_q <= '0;
      out_target_q <= '0;
      out_wrap_q   <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_branch_q <= out_branch_d;
      out_offset_q <= out_offset_d;
      out_target_q <= out_target_d;
      out_wrap_q   <= out_wrap_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_is_branch = out_branch_q;
  assign out_offset    = out_offset_q;
  assign out_target    = out_target_q;
  assign out_wrap      = out_wrap_q;

endmodule

// File: doc/branch_target_id.md
# branch_target_id

Parametrised ID-stage branch-target unit for the pipelined processor. Extends a branch immediate (sign or zero), scales it by a configurable shift (0 for our instruction-addressed PC, 2 for byte-addressed), adds it to the sequential PC, and delivers offset, target and a wrap flag through a 1- or 2-stage pipeline. The pipeline has stall and flush control and sits between the decoder and the ID/EX register.

## Interface
Parameters:
- IMM_W, 16: immediate width.
- DATA_W, 32: extended offset width; must be ≥ IMM_W.
- ADDR_W, 32: PC width; must be ≤ DATA_W.
- SHIFT, 0: left shift applied to the extended immediate; legal range 0..3.
- PIPE, 2: pipeline depth; legal values 1 or 2.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- in_valid  in  1  input fields are valid this cycle.
- is_branch  in  1  instruction is a branch; carried alongside the data.
- sign_mode  in  1  1 = sign-extend imm, 0 = zero-extend.
- imm  in  IMM_W  raw immediate field.
- pc_next  in  ADDR_W  PC of the following instruction.
- stall  in  1  hold all stages.
- flush  in  1  kill all in-flight entries.
- out_valid  out  1  outputs are valid.
- out_is_branch  out  1  delayed is_branch.
- out_offset  out  DATA_W  extended and shifted immediate.
- out_target  out  ADDR_W  pc_next + offset, modulo 2^ADDR_W.
- out_wrap  out  1  exact target lies outside [0, 2^ADDR_W−1].

## Operation
- ext = imm extended to DATA_W per sign_mode. offset = (ext << SHIFT) truncated to DATA_W; bits shifted out are discarded.
- Target arithmetic:
  - pc_next is unsigned.
  - offset[ADDR_W-1:0] is signed when sign_mode=1, unsigned otherwise.
  - target is the low ADDR_W bits of the sum.
  - wrap=1 when the exact sum is <0 or ≥2^ADDR_W.
- PIPE=2:
  - Stage 1 registers valid, is_branch, sign_mode, pc_next and offset.
  - Stage 2 registers valid, is_branch, offset, target and wrap.
  - The adder lives between the two stages.
- PIPE=1: a single register captures all outputs; extension, shift and add are combinational in front of it.
- Each stage is a valid-tagged register. Per-stage control states, in priority order:
  - flush: valid←0, data don't-care.
  - stall (and no flush): hold everything.
  - otherwise: advance; stage-1 valid←in_valid.
- While stall=1, upstream holds its inputs; the block ignores in_valid.
- Data registers load regardless of valid; only valid bits are cleared by flush.

## Timing
- Reset (rst_n low, asynchronous): all valid bits and all output registers go to 0. Every output reads 0 during reset and until the first valid result emerges.
- Latency: PIPE cycles from an accepted in_valid to out_valid, with no stall. Throughput is one item per cycle.
- Stall:
  - Adds exactly one cycle of latency per stalled cycle.
  - Outputs stay stable and unchanged while stalled.
  - Order is preserved and nothing is dropped or duplicated.
- Flush:
  - On the edge where flush=1, all stages, including the input being presented, become invalid.
  - out_valid=0 from the next cycle until new data propagates.
- Simultaneous flush+stall: flush wins.
- Simultaneous flush+in_valid: the input is discarded.
- Reset mid-operation: in-flight entries are lost and outputs clear immediately. The first accepted input after rst_n rises emerges PIPE cycles later.
- out_wrap, out_target and out_offset are registered; there are no combinational input-to-output paths.

## Test plan
All scenarios use DATA_W=ADDR_W=32 and IMM_W=16, with PIPE=2 unless stated.

1. Reset: assert rst_n=0 mid-stream with two valid entries in flight -> all outputs 0 immediately; after release, out_valid stays 0 until a new input arrives 2 cycles earlier.
2. Sign extension: SHIFT=0, imm=16'hFFFE, sign_mode=1, pc_next=32'h10 -> 2 cycles later out_offset=32'hFFFFFFFE, out_target=32'h0E, out_wrap=0; with sign_mode=0 -> offset 32'h0000FFFE, target 32'h0001000E.
3. Wrap: imm=16'h0004, pc_next=32'hFFFFFFFE, sign -> target 32'h2, wrap=1; imm=16'hFFFF, pc_next=0, sign -> target 32'hFFFFFFFF, wrap=1.
4. Stall: stream imm 1, 2, 3 back-to-back and assert stall for 3 cycles after the second input -> outputs frozen during stall, then offsets 1, 2, 3 appear in order, each exactly once.
5. Flush: assert flush and stall together with two entries in flight plus in_valid=1 -> next cycle out_valid=0 and stays 0 for 2 cycles; no flushed offset ever appears.
6. Parameters: SHIFT=2, PIPE=1, imm=16'h0003 -> offset 32'hC after 1 cycle; imm=16'h8000, sign -> offset 32'hFFFE0000, and the top shifted-out bits are discarded.
